// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, bit-period helper and frame constants.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles per serial bit (integer division, caller guarantees >= 2).
    function automatic int clk_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count. Push is ignored when full, pop is
// ignored when empty. The head entry is always visible on data_o.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small FIFO.
// The line register lags the FSM state by one cycle, so a byte written into an
// idle block shows its start bit two cycles after the accepting edge.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CPB   = clk_per_bit(CLOCK_HZ, BAUD_RATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_state_t                state_q;
    logic [CNT_W-1:0]           clk_cnt_q;
    logic [BIT_W-1:0]           bit_idx_q;
    logic [UART_DATA_BITS-1:0]  sh_q;
    logic                       tx_q;

    logic                       fifo_full, fifo_empty, fifo_pop;
    logic [UART_DATA_BITS-1:0]  fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       bit_end;

    assign fifo_pop     = (state_q == IDLE) && !fifo_empty;
    assign bit_end      = (clk_cnt_q == CNT_LAST);
    assign o_ready      = !fifo_full;
    assign o_uart_tx    = tx_q;
    assign o_busy       = (state_q != IDLE) || (fifo_count != '0);
    assign o_fifo_count = fifo_count;

    uart_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push_i  (i_valid),
        .data_i  (i_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Frame sequencer: the line level is registered from the current state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        sh_q      <= fifo_head;
                        clk_cnt_q <= '0;
                        state_q   <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    tx_q <= sh_q[bit_idx_q];
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == BIT_LAST) state_q <= STOP;
                        else                       bit_idx_q <= bit_idx_q + BIT_W'(1);
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q      <= 1'b1;
                    clk_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
